// File: rtl/mux_sel_sequencer_pkg.sv
// Shared constants, state encoding and select arithmetic for the CombMux8 select sequencer.
package mux_sel_sequencer_pkg;

   localparam int unsigned SEL_W  = 3;
   localparam int unsigned NUM_IN = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_ISSUE = 2'd2
   } state_e;

   // Stride step with natural 3-bit wrap (modulo NUM_IN).
   function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx,
                                                 input logic [SEL_W-1:0] step);
      return SEL_W'(idx + step);
   endfunction

endpackage

// File: rtl/mux_sel_hold_cnt.sv
// Loadable down-counter with a registered zero flag; used for delay and hold countdowns.
module mux_sel_hold_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Load takes priority; decrement saturates at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         zero <= 1'b1;
      end else if (load) begin
         cnt  <= load_val;
         zero <= (load_val == '0);
      end else if (dec && !zero) begin
         cnt  <= W'(cnt - W'(1));
         zero <= (cnt == W'(1));
      end
   end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Steps the CombMux8 select through start/stride/hold/count after a run pulse.
// Optional looping with stop control is enabled by defining MUX_SEL_SEQ_LOOP_EN.
module mux_sel_sequencer
   import mux_sel_sequencer_pkg::*;
#(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned HOLD_W  = 8,
   parameter int unsigned DELAY_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   output logic               running,
   output logic               done,
   input  logic [SEL_W-1:0]   cfg_start,
   input  logic [SEL_W-1:0]   cfg_step,
   input  logic [CNT_W-1:0]   cfg_count,
   input  logic [HOLD_W-1:0]  cfg_hold,
   input  logic [DELAY_W-1:0] cfg_delay,
`ifdef MUX_SEL_SEQ_LOOP_EN
   input  logic               stop,
   input  logic               cfg_loop,
`endif
   output logic [SEL_W-1:0]   sel,
   output logic               sel_valid
);

   logic stop_in;
   logic loop_in;
`ifdef MUX_SEL_SEQ_LOOP_EN
   assign stop_in = stop;
   assign loop_in = cfg_loop;
`else
   assign stop_in = 1'b0;
   assign loop_in = 1'b0;
`endif

   state_e             state;
   logic [SEL_W-1:0]   idx_q;
   logic [CNT_W-1:0]   issued_q;
   logic [SEL_W-1:0]   start_q;
   logic [SEL_W-1:0]   step_q;
   logic [CNT_W-1:0]   count_q;
   logic [HOLD_W-1:0]  hold_q;
   logic               loop_q;
   logic               stop_req_q;

   logic               delay_load;
   logic               delay_dec;
   logic               delay_zero;
   logic               hold_load;
   logic               hold_dec;
   logic [HOLD_W-1:0]  hold_val;
   logic               hold_zero;
   logic               last_sel;

   assign sel      = idx_q;
   assign last_sel = (issued_q == CNT_W'(count_q - CNT_W'(1)));

   // Countdown control: delay counts cfg_delay cycles, hold counts cfg_hold+1 per select.
   always_comb begin
      delay_load = 1'b0;
      delay_dec  = 1'b0;
      hold_load  = 1'b0;
      hold_dec   = 1'b0;
      hold_val   = hold_q;
      unique case (state)
         ST_IDLE: begin
            if (run) begin
               if (cfg_delay != '0) begin
                  delay_load = 1'b1;
               end else if (cfg_count != '0) begin
                  hold_load = 1'b1;
                  hold_val  = cfg_hold;
               end
            end
         end
         ST_DELAY: begin
            if (!delay_zero) delay_dec = 1'b1;
            else             hold_load = 1'b1;
         end
         ST_ISSUE: begin
            if (hold_zero) hold_load = 1'b1;
            else           hold_dec  = 1'b1;
         end
         default: ;
      endcase
   end

   mux_sel_hold_cnt #(.W(DELAY_W)) u_delay_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (delay_load),
      .load_val (DELAY_W'(cfg_delay - DELAY_W'(1))),
      .dec      (delay_dec),
      .zero     (delay_zero)
   );

   mux_sel_hold_cnt #(.W(HOLD_W)) u_hold_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (hold_load),
      .load_val (hold_val),
      .dec      (hold_dec),
      .zero     (hold_zero)
   );

   // Sequencer FSM with registered outputs; any exit to IDLE raises done and drops sel_valid together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx_q      <= '0;
         issued_q   <= '0;
         start_q    <= '0;
         step_q     <= '0;
         count_q    <= '0;
         hold_q     <= '0;
         loop_q     <= 1'b0;
         stop_req_q <= 1'b0;
         running    <= 1'b0;
         done       <= 1'b1;
         sel_valid  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               done       <= 1'b1;
               stop_req_q <= 1'b0;
               if (run) begin
                  start_q  <= cfg_start;
                  step_q   <= cfg_step;
                  count_q  <= cfg_count;
                  hold_q   <= cfg_hold;
                  loop_q   <= loop_in;
                  done     <= 1'b0;
                  issued_q <= '0;
                  if (cfg_delay != '0) begin
                     state   <= ST_DELAY;
                     running <= 1'b1;
                  end else if (cfg_count != '0) begin
                     state     <= ST_ISSUE;
                     running   <= 1'b1;
                     sel_valid <= 1'b1;
                     idx_q     <= cfg_start;
                  end
               end
            end
            ST_DELAY: begin
               if (stop_in || (delay_zero && count_q == '0)) begin
                  state     <= ST_IDLE;
                  running   <= 1'b0;
                  done      <= 1'b1;
               end else if (delay_zero) begin
                  state     <= ST_ISSUE;
                  sel_valid <= 1'b1;
                  idx_q     <= start_q;
                  issued_q  <= '0;
               end
            end
            ST_ISSUE: begin
               stop_req_q <= stop_req_q | stop_in;
               if (hold_zero) begin
                  if (stop_req_q || stop_in || (last_sel && !loop_q)) begin
                     state      <= ST_IDLE;
                     running    <= 1'b0;
                     done       <= 1'b1;
                     sel_valid  <= 1'b0;
                     stop_req_q <= 1'b0;
                  end else if (last_sel) begin
                     idx_q    <= start_q;
                     issued_q <= '0;
                  end else begin
                     idx_q    <= next_idx(idx_q, step_q);
                     issued_q <= CNT_W'(issued_q + CNT_W'(1));
                  end
               end
            end
            default: begin
               state     <= ST_IDLE;
               running   <= 1'b0;
               done      <= 1'b1;
               sel_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
